// File: rtl/led_sequence_player_pkg.sv
// Shared colour codes and controller state encoding for the LED sequence player.
// Colour code doubles as the LED bit index: 0 red, 1 blue, 2 green, 3 yellow.
package led_sequence_player_pkg;

  localparam logic [1:0] COLOR_RED    = 2'd0;
  localparam logic [1:0] COLOR_BLUE   = 2'd1;
  localparam logic [1:0] COLOR_GREEN  = 2'd2;
  localparam logic [1:0] COLOR_YELLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHOW,
    ST_GAP,
    ST_FLASH_PRE,
    ST_FLASH_ON,
    ST_FLASH_OFF,
    ST_ECHO
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_sequence_player_led_decoder.sv
// Combinational LED selector: all four, exactly one (by colour), or none.
// Latency 0; no flow control.
module led_decoder
  import led_sequence_player_pkg::*;
(
  input  logic [1:0] i_color,
  input  logic       i_one_hot_en,
  input  logic       i_all_en,
  output logic [3:0] o_leds
);

  always_comb begin
    o_leds = 4'b0000;
    if (i_all_en) begin
      o_leds = 4'b1111;
    end else if (i_one_hot_en) begin
      case (i_color)
        COLOR_RED:    o_leds = 4'b0001;
        COLOR_BLUE:   o_leds = 4'b0010;
        COLOR_GREEN:  o_leds = 4'b0100;
        COLOR_YELLOW: o_leds = 4'b1000;
        default:      o_leds = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/led_sequence_player.sv
// Owns the four game LEDs: sequence playback, flash-all indication and player echo.
// All outputs registered; start/press are dropped while busy, flash_req preempts everything but a flash.
module led_sequence_player
  import led_sequence_player_pkg::*;
#(
  parameter int CLOCK_FREQ       = 50000000,
  parameter int ON_CYCLES        = CLOCK_FREQ / 2,
  parameter int OFF_CYCLES       = CLOCK_FREQ / 4,
  parameter int FLASH_ON_CYCLES  = CLOCK_FREQ,
  parameter int FLASH_OFF_CYCLES = CLOCK_FREQ / 2,
  parameter int FLASH_COUNT      = 3,
  parameter int ECHO_CYCLES      = CLOCK_FREQ / 5,
  parameter int MAX_LEN          = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] seq_len,
  output logic [4:0] seq_addr,
  input  logic [1:0] seq_color,
  input  logic       flash_req,
  input  logic       press_valid,
  input  logic [1:0] press_color,
  output logic       busy,
  output logic       done,
  output logic       flash_done,
  output logic       red_led,
  output logic       blue_led,
  output logic       green_led,
  output logic       yellow_led
);

  localparam int MAX_T = max2(max2(max2(ON_CYCLES, OFF_CYCLES),
                                   max2(FLASH_ON_CYCLES, FLASH_OFF_CYCLES)), ECHO_CYCLES);
  localparam int CW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int FW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  localparam logic [CW-1:0] LD_ON        = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] LD_OFF       = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] LD_FLASH_ON  = CW'(FLASH_ON_CYCLES - 1);
  localparam logic [CW-1:0] LD_FLASH_OFF = CW'(FLASH_OFF_CYCLES - 1);
  localparam logic [CW-1:0] LD_ECHO      = CW'(ECHO_CYCLES - 1);
  localparam logic [FW-1:0] LD_FLASH_N   = FW'(FLASH_COUNT - 1);
  localparam logic [5:0]    MAX_LEN_L    = 6'(MAX_LEN);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_flash_left;
  logic [4:0]    r_idx;
  logic [5:0]    r_len;
  logic [1:0]    r_color;
  logic [4:0]    r_seq_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_flash_done;
  logic [3:0]    r_leds;

  logic       w_cnt_zero;
  logic       w_last_step;
  logic       w_preempt;
  logic [5:0] w_len_clamped;
  logic [1:0] w_dec_color;
  logic       w_dec_one;
  logic       w_dec_all;
  logic [3:0] w_leds;

  assign w_cnt_zero    = (r_cnt == '0);
  assign w_last_step   = ({1'b0, r_idx} == (r_len - 6'd1));
  assign w_len_clamped = (seq_len > MAX_LEN_L) ? MAX_LEN_L : seq_len;
  assign w_preempt     = flash_req && ((r_state == ST_FETCH) || (r_state == ST_SHOW) ||
                                       (r_state == ST_GAP)   || (r_state == ST_ECHO));

  // LED image for the next cycle, so the LED register lines up with the state register.
  always_comb begin
    w_dec_color = r_color;
    w_dec_one   = 1'b0;
    w_dec_all   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flash_req) begin
          w_dec_all = 1'b1;
        end else if (!start && press_valid) begin
          w_dec_one   = 1'b1;
          w_dec_color = press_color;
        end
      end
      ST_FETCH: begin
        w_dec_one   = !flash_req;
        w_dec_color = seq_color;
      end
      ST_SHOW:      w_dec_one = !flash_req && !w_cnt_zero;
      ST_GAP:       w_dec_one = 1'b0;
      ST_FLASH_PRE: w_dec_all = 1'b1;
      ST_FLASH_ON:  w_dec_all = !w_cnt_zero;
      ST_FLASH_OFF: w_dec_all = w_cnt_zero && (r_flash_left != '0);
      ST_ECHO:      w_dec_one = !flash_req && !w_cnt_zero;
      default:      w_dec_one = 1'b0;
    endcase
  end

  led_decoder u_led_decoder (
    .i_color      (w_dec_color),
    .i_one_hot_en (w_dec_one),
    .i_all_en     (w_dec_all),
    .o_leds       (w_leds)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_flash_left <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_color      <= COLOR_RED;
      r_seq_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_flash_done <= 1'b0;
      r_leds       <= '0;
    end else begin
      r_done       <= 1'b0;
      r_flash_done <= 1'b0;
      r_leds       <= w_leds;
      if (w_preempt) begin
        r_state      <= ST_FLASH_PRE;
        r_flash_left <= LD_FLASH_N;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (flash_req) begin
              r_state      <= ST_FLASH_ON;
              r_cnt        <= LD_FLASH_ON;
              r_flash_left <= LD_FLASH_N;
              r_busy       <= 1'b1;
            end else if (start) begin
              if (seq_len == 6'd0) begin
                r_done <= 1'b1;
              end else begin
                r_state    <= ST_FETCH;
                r_len      <= w_len_clamped;
                r_idx      <= '0;
                r_seq_addr <= '0;
                r_busy     <= 1'b1;
              end
            end else if (press_valid) begin
              r_state <= ST_ECHO;
              r_color <= press_color;
              r_cnt   <= LD_ECHO;
              r_busy  <= 1'b1;
            end
          end
          ST_FETCH: begin
            r_color <= seq_color;
            r_cnt   <= LD_ON;
            r_state <= ST_SHOW;
          end
          ST_SHOW: begin
            if (w_cnt_zero) begin
              r_cnt   <= LD_OFF;
              r_state <= ST_GAP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (w_last_step) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx      <= r_idx + 5'd1;
              r_seq_addr <= r_idx + 5'd1;
              r_state    <= ST_FETCH;
            end
          end
          ST_FLASH_PRE: begin
            r_cnt   <= LD_FLASH_ON;
            r_state <= ST_FLASH_ON;
          end
          ST_FLASH_ON: begin
            if (w_cnt_zero) begin
              r_cnt   <= LD_FLASH_OFF;
              r_state <= ST_FLASH_OFF;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_FLASH_OFF: begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - 1'b1;
            end else if (r_flash_left == '0) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_flash_done <= 1'b1;
            end else begin
              r_flash_left <= r_flash_left - 1'b1;
              r_cnt        <= LD_FLASH_ON;
              r_state      <= ST_FLASH_ON;
            end
          end
          ST_ECHO: begin
            if (w_cnt_zero) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seq_addr   = r_seq_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign flash_done = r_flash_done;
  assign red_led    = r_leds[0];
  assign blue_led   = r_leds[1];
  assign green_led  = r_leds[2];
  assign yellow_led = r_leds[3];

endmodule

// File: tb/tb_led_sequence_player.sv
// Randomized self-checking bench for led_sequence_player with shortened timing parameters.
module tb_led_sequence_player;

  localparam int ON     = 4;
  localparam int OFF    = 2;
  localparam int F_ON   = 3;
  localparam int F_OFF  = 3;
  localparam int F_N    = 2;
  localparam int ECHO   = 5;
  localparam int STEP   = 1 + ON + OFF;
  localparam int F_LEN  = F_N * (F_ON + F_OFF);

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [5:0] seq_len = '0;
  logic [4:0] seq_addr;
  logic [1:0] seq_color;
  logic       flash_req = 1'b0;
  logic       press_valid = 1'b0;
  logic [1:0] press_color = '0;
  logic       busy, done, flash_done;
  logic       red_led, blue_led, green_led, yellow_led;

  logic [1:0] ram [32];
  int n_checks = 0;
  int n_errors = 0;

  assign seq_color = ram[seq_addr];

  always #5 clock = ~clock;

  led_sequence_player #(
    .ON_CYCLES(ON), .OFF_CYCLES(OFF), .FLASH_ON_CYCLES(F_ON), .FLASH_OFF_CYCLES(F_OFF),
    .FLASH_COUNT(F_N), .ECHO_CYCLES(ECHO), .MAX_LEN(32)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .seq_len(seq_len), .seq_addr(seq_addr),
    .seq_color(seq_color), .flash_req(flash_req), .press_valid(press_valid),
    .press_color(press_color), .busy(busy), .done(done), .flash_done(flash_done),
    .red_led(red_led), .blue_led(blue_led), .green_led(green_led), .yellow_led(yellow_led)
  );

  function automatic logic [3:0] leds();
    return {yellow_led, green_led, blue_led, red_led};
  endfunction

  // Playback reference: cycle c after the start edge; each step is one dark fetch cycle,
  // ON lit cycles of the stored colour, then OFF dark cycles.
  function automatic logic [3:0] play_led(input int c);
    int k, step, ph;
    logic [3:0] one;
    k = c - 1;
    step = k / STEP;
    ph = k % STEP;
    one = 4'b0001 << ram[step];
    return (ph >= 1 && ph <= ON) ? one : 4'b0000;
  endfunction

  // Flash reference: f counts cycles from the first all-on cycle (0-based).
  function automatic logic [3:0] flash_led(input int f);
    return ((f % (F_ON + F_OFF)) < F_ON) ? 4'b1111 : 4'b0000;
  endfunction

  task automatic fill_ram_random();
    for (int i = 0; i < 32; i++) ram[i] = 2'($urandom);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({leds(), busy, done, flash_done, seq_addr} !== 12'd0) begin
      n_errors++;
      $display("FAIL reset_state got leds=%b busy=%b done=%b fdone=%b addr=%0d want all 0",
               leds(), busy, done, flash_done, seq_addr);
    end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_playback();
    int lens[4];
    int eff, total, k;
    logic [3:0] el;
    lens[0] = 3; lens[1] = 0; lens[2] = 40; lens[3] = $urandom_range(1, 6);
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        ram[0] = 2'd0; ram[1] = 2'd2; ram[2] = 2'd3;
      end else begin
        fill_ram_random();
      end
      eff = (lens[t] > 32) ? 32 : lens[t];
      total = eff * STEP + 1;
      seq_len = 6'(lens[t]);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 1; c <= total; c++) begin
        k = c - 1;
        el = (c < total) ? play_led(c) : 4'b0000;
        n_checks++;
        if (leds() !== el) begin
          n_errors++;
          $display("FAIL play_leds len=%0d cyc=%0d got %b want %b", lens[t], c, leds(), el);
        end
        n_checks++;
        if (done !== (c == total) || busy !== (c < total)) begin
          n_errors++;
          $display("FAIL play_done_busy len=%0d cyc=%0d got done=%b busy=%b want done=%b busy=%b",
                   lens[t], c, done, busy, c == total, c < total);
        end
        if (c < total && (k % STEP) == 0) begin
          n_checks++;
          if (seq_addr !== 5'(k / STEP)) begin
            n_errors++;
            $display("FAIL play_addr len=%0d cyc=%0d got %0d want %0d", lens[t], c, seq_addr, k / STEP);
          end
        end
        // start/press while busy must be dropped
        if (c < total) begin
          start = 1'($urandom_range(0, 1));
          seq_len = 6'($urandom);
          press_valid = 1'($urandom_range(0, 1));
          press_color = 2'($urandom);
        end else begin
          start = 1'b0;
          press_valid = 1'b0;
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_flash_preempt();
    int ca;
    logic [3:0] el;
    fill_ram_random();
    ca = 9 + $urandom_range(0, 3);
    seq_len = 6'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= ca; c++) begin
      n_checks++;
      if (leds() !== play_led(c)) begin
        n_errors++;
        $display("FAIL preempt_play cyc=%0d got %b want %b", c, leds(), play_led(c));
      end
      if (c == ca) flash_req = 1'b1;
      @(negedge clock);
    end
    flash_req = 1'b0;
    for (int j = 1; j <= F_LEN + 2; j++) begin
      el = (j == 1 || j == F_LEN + 2) ? 4'b0000 : flash_led(j - 2);
      n_checks++;
      if (leds() !== el) begin
        n_errors++;
        $display("FAIL preempt_flash_leds j=%0d got %b want %b", j, leds(), el);
      end
      n_checks++;
      if (done !== 1'b0 || flash_done !== (j == F_LEN + 2) || busy !== (j < F_LEN + 2)) begin
        n_errors++;
        $display("FAIL preempt_flags j=%0d got done=%b fdone=%b busy=%b want 0 %b %b",
                 j, done, flash_done, busy, j == F_LEN + 2, j < F_LEN + 2);
      end
      if (j >= 2 && j < F_LEN + 1) begin
        flash_req = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        seq_len = 6'd2;
        press_valid = 1'($urandom_range(0, 1));
      end else begin
        flash_req = 1'b0; start = 1'b0; press_valid = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_echo();
    logic [1:0] col;
    logic [3:0] el;
    for (int t = 0; t < 3; t++) begin
      col = (t == 0) ? 2'd1 : 2'($urandom);
      press_color = col;
      press_valid = 1'b1;
      @(negedge clock);
      press_valid = 1'b0;
      for (int c = 1; c <= ECHO + 1; c++) begin
        el = (c <= ECHO) ? (4'b0001 << col) : 4'b0000;
        n_checks++;
        if (leds() !== el || busy !== (c <= ECHO) || done !== 1'b0) begin
          n_errors++;
          $display("FAIL echo col=%0d cyc=%0d got leds=%b busy=%b done=%b want leds=%b busy=%b done=0",
                   col, c, leds(), busy, done, el, c <= ECHO);
        end
        if (c < ECHO) begin
          press_valid = 1'b1;
          press_color = col + 2'd1;
          start = 1'b1;
          seq_len = 6'd1;
        end else begin
          press_valid = 1'b0;
          start = 1'b0;
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_flash_vs_start();
    logic [3:0] el;
    fill_ram_random();
    flash_req = 1'b1;
    start = 1'b1;
    seq_len = 6'd3;
    press_valid = 1'b1;
    @(negedge clock);
    flash_req = 1'b0; start = 1'b0; press_valid = 1'b0;
    for (int c = 1; c <= F_LEN + 4; c++) begin
      el = (c <= F_LEN) ? flash_led(c - 1) : 4'b0000;
      n_checks++;
      if (leds() !== el || done !== 1'b0 || flash_done !== (c == F_LEN + 1) || busy !== (c <= F_LEN)) begin
        n_errors++;
        $display("FAIL flash_vs_start cyc=%0d got leds=%b done=%b fdone=%b busy=%b want leds=%b done=0 fdone=%b busy=%b",
                 c, leds(), done, flash_done, busy, el, c == F_LEN + 1, c <= F_LEN);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_show();
    fill_ram_random();
    seq_len = 6'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (leds() !== (4'b0001 << ram[0])) begin
      n_errors++;
      $display("FAIL mid_show_lit got %b want %b", leds(), 4'b0001 << ram[0]);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (leds() !== 4'b0000 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got leds=%b busy=%b want 0000 0", leds(), busy);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    seq_len = 6'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= STEP + 1; c++) begin
      n_checks++;
      if (leds() !== ((c <= STEP) ? play_led(c) : 4'b0000) || done !== (c == STEP + 1)) begin
        n_errors++;
        $display("FAIL after_reset_play cyc=%0d got leds=%b done=%b want leds=%b done=%b",
                 c, leds(), done, (c <= STEP) ? play_led(c) : 4'b0000, c == STEP + 1);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 2'd0;
    test_reset();
    test_playback();
    test_flash_preempt();
    test_echo();
    test_flash_vs_start();
    test_reset_mid_show();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
